// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Drives a column-multiplexed LED matrix from a double-buffered frame bitmap.
//   A frame written by the frame source is staged first. It becomes the
//   displayed frame only when the scan wraps from the last column back to
//   column 0, so the matrix never tears. Each column slot ends with a guard
//   gap in which every row and every column is off, which suppresses ghosting.
//
//   Optional feature: define BRIGHTNESS_PWM_EN to add the brightness_i[3:0]
//   input. Row drive in the ON phase is then gated by a free-running 4-bit PWM
//   counter (duty = brightness_i/16). Column drive is not affected.
//
// Ports
//   clk_50mhz      in   system clock
//   init_pulse     in   synchronous active-high reset
//   brightness_i   in   [3:0] row PWM duty (present only with BRIGHTNESS_PWM_EN)
//   frame_i        in   [N_ROWS*N_COLS] bitmap; bits [c*N_ROWS +: N_ROWS] = column c
//   frame_valid_i  in   one-cycle strobe; stage frame_i
//   blank_i        in   level; force the matrix dark while scanning continues
//   rows_status    out  [N_ROWS] row drive, active-high
//   columns_status out  [N_COLS] column drive, active-low
//   frame_ack_o    out  one-cycle pulse when a new frame becomes the displayed frame
//   col_idx_o      out  [2:0] index of the current column slot
module led_matrix_scanner #(
  parameter int N_ROWS    = 7,
  parameter int N_COLS    = 5,
  parameter int COL_TICKS = 50000,
  parameter int GUARD     = 500
) (
  input  logic                     clk_50mhz,
  input  logic                     init_pulse,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]               brightness_i,
`endif
  input  logic [N_ROWS*N_COLS-1:0] frame_i,
  input  logic                     frame_valid_i,
  input  logic                     blank_i,
  output logic [N_ROWS-1:0]        rows_status,
  output logic [N_COLS-1:0]        columns_status,
  output logic                     frame_ack_o,
  output logic [2:0]               col_idx_o
);

  localparam int FW = N_ROWS * N_COLS;
  localparam int TW = $clog2(COL_TICKS);

  typedef enum logic {
    ST_ON  = 1'b0,
    ST_GAP = 1'b1
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick;
  logic [FW-1:0]     active;
  logic [FW-1:0]     staging;
  logic              pending;

  logic              tick_wrap;
  logic              gap_start;
  logic              last_col;
  logic              boundary;
  logic              pwm_on;
  logic [N_ROWS-1:0] col_rows;
  logic [N_COLS-1:0] col_sel;

  assign tick_wrap = (tick == TW'(COL_TICKS - 1));
  assign gap_start = (tick == TW'(COL_TICKS - GUARD - 1));
  assign last_col  = (col_idx_o == 3'(N_COLS - 1));
  assign boundary  = tick_wrap && last_col;
  assign col_rows  = active[int'(col_idx_o) * N_ROWS +: N_ROWS];
  assign col_sel   = N_COLS'(1) << col_idx_o;

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] pwm;

  assign pwm_on = (pwm < brightness_i);

  always_ff @(posedge clk_50mhz) begin
    if (init_pulse) pwm <= '0;
    else            pwm <= pwm + 4'd1;
  end
`else
  assign pwm_on = 1'b1;
`endif

  always_ff @(posedge clk_50mhz) begin
    if (init_pulse) begin
      state          <= ST_ON;
      tick           <= '0;
      col_idx_o      <= '0;
      active         <= '0;
      staging        <= '0;
      pending        <= 1'b0;
      rows_status    <= '0;
      columns_status <= '1;
      frame_ack_o    <= 1'b0;
    end else begin
      tick <= tick_wrap ? '0 : tick + TW'(1);

      if (tick_wrap)
        col_idx_o <= last_col ? '0 : col_idx_o + 3'd1;

      case (state)
        ST_ON:   if (gap_start) state <= ST_GAP;
        ST_GAP:  if (tick_wrap) state <= ST_ON;
        default: state <= ST_ON;
      endcase

      // Drive follows the state the counter is in now, so it lags by one cycle.
      if (state == ST_ON) begin
        rows_status    <= col_rows & {N_ROWS{~blank_i & pwm_on}};
        columns_status <= ~col_sel;
      end else begin
        rows_status    <= '0;
        columns_status <= '1;
      end

      // A strobe on the boundary cycle itself goes straight to the active
      // buffer; otherwise it waits in staging until the next boundary.
      frame_ack_o <= 1'b0;
      if (boundary) begin
        if (frame_valid_i) begin
          active      <= frame_i;
          staging     <= frame_i;
          frame_ack_o <= 1'b1;
        end else if (pending) begin
          active      <= staging;
          frame_ack_o <= 1'b1;
        end
        pending <= 1'b0;
      end else if (frame_valid_i) begin
        staging <= frame_i;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner
//   Directed bench for led_matrix_scanner with COL_TICKS=8, GUARD=2.
//   n counts rising edges since reset release (edge 0 is the first edge with
//   init_pulse low). After edge n: slot k = n/8, phase j = n%8; column k%5 is
//   driven for j<6, dark for j=6,7; col_idx_o moves to the next column at j=7.
//   Frame boundaries are the edges with n%40 == 39.
module tb_led_matrix_scanner;

  logic        clk_50mhz = 1'b0;
  logic        init_pulse;
  logic [34:0] frame_i;
  logic        frame_valid_i;
  logic        blank_i;
  logic [6:0]  rows_status;
  logic [4:0]  columns_status;
  logic        frame_ack_o;
  logic [2:0]  col_idx_o;

  int          checks = 0;
  int          errors = 0;
  int          n;
  int          ack_n;
  logic [6:0]  exp_rows [5];

  always #5 clk_50mhz = ~clk_50mhz;

  led_matrix_scanner #(
    .N_ROWS   (7),
    .N_COLS   (5),
    .COL_TICKS(8),
    .GUARD    (2)
  ) dut (
    .clk_50mhz     (clk_50mhz),
    .init_pulse    (init_pulse),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .blank_i       (blank_i),
    .rows_status   (rows_status),
    .columns_status(columns_status),
    .frame_ack_o   (frame_ack_o),
    .col_idx_o     (col_idx_o)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rows"}, 35'(rows_status), 35'h0);
    chk({tag, "_cols"}, 35'(columns_status), 35'h1F);
    chk({tag, "_ack"},  35'(frame_ack_o), 35'h0);
    chk({tag, "_cidx"}, 35'(col_idx_o), 35'h0);
  endtask

  task automatic check_slot();
    int         k, j, slot;
    logic [4:0] oh;
    logic [4:0] ecol;
    logic [6:0] erows;
    logic [2:0] ecidx;
    k     = n / 8;
    j     = n % 8;
    slot  = k % 5;
    oh    = 5'b00001 << slot;
    ecol  = (j < 6) ? ~oh : 5'h1F;
    erows = (j < 6 && !blank_i) ? exp_rows[slot] : 7'h00;
    ecidx = 3'((j == 7) ? (k + 1) % 5 : slot);
    chk("columns", 35'(columns_status), 35'(ecol));
    chk("rows",    35'(rows_status),    35'(erows));
    chk("col_idx", 35'(col_idx_o),      35'(ecidx));
    chk("ack",     35'(frame_ack_o),    35'(n == ack_n));
  endtask

  task automatic step();
    @(negedge clk_50mhz);
    n++;
    check_slot();
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic strobe(input logic [34:0] v);
    frame_i       = v;
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 5; i++) exp_rows[i] = 7'h00;
    ack_n = -1;
  endtask

  initial begin
    init_pulse    = 1'b1;
    frame_i       = '0;
    frame_valid_i = 1'b0;
    blank_i       = 1'b0;
    n             = 0;
    clear_exp();

    repeat (3) @(negedge clk_50mhz);
    check_reset_values("reset");

    // Idle scan, empty frame
    init_pulse = 1'b0;
    @(negedge clk_50mhz);
    n = 0;
    check_slot();
    run_to(79);

    // Single strobe in slot 2, swapped at the n=119 boundary
    run_to(97);
    ack_n = 119;
    strobe(35'h1);
    run_to(119);
    exp_rows[0] = 7'h01;
    run_to(129);

    // Two strobes in one frame: the later one wins, one ack
    ack_n = 159;
    strobe(35'h1);
    run_to(139);
    strobe(35'h7F << 7);
    run_to(159);
    exp_rows[0] = 7'h00;
    exp_rows[1] = 7'h7F;

    // Strobe exactly on the boundary cycle bypasses staging
    run_to(198);
    ack_n = 199;
    strobe(35'h7F);
    exp_rows[0] = 7'h7F;
    exp_rows[1] = 7'h00;
    run_to(205);

    // Full frame, then blanking while the scan continues
    ack_n = 239;
    strobe(35'h7_FFFF_FFFF);
    run_to(239);
    for (int i = 0; i < 5; i++) exp_rows[i] = 7'h7F;
    run_to(250);
    blank_i = 1'b1;
    run_to(264);
    blank_i = 1'b0;
    step();
    run_to(304);

    // Reset mid-scan in slot 3 with a frame loaded
    init_pulse = 1'b1;
    @(negedge clk_50mhz);
    check_reset_values("midreset");
    init_pulse = 1'b0;
    clear_exp();
    @(negedge clk_50mhz);
    n = 0;
    check_slot();
    run_to(47);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
